// File: rtl/xor_net_bist_if.sv
// Signal bundle between the XOR-network self-test sequencer and whoever
// hosts it: run control and status, plus the three operand lanes and the result.
interface xor_net_bist_if #(
  parameter int DATA_W = 16
);
  logic                     start;
  logic signed [DATA_W-1:0] net_a;
  logic signed [DATA_W-1:0] net_b;
  logic signed [DATA_W-1:0] net_c;
  logic signed [DATA_W-1:0] net_result;
  logic                     busy;
  logic                     done;
  logic                     pass;
  logic [7:0]               fail_mask;
  logic [7:0]               result_bits;
  logic [2:0]               pattern_idx;

  // Host side: requests runs, feeds back the network output.
  modport master (
    output start, net_result,
    input  net_a, net_b, net_c, busy, done, pass, fail_mask, result_bits, pattern_idx
  );

  // Sequencer side.
  modport slave (
    input  start, net_result,
    output net_a, net_b, net_c, busy, done, pass, fail_mask, result_bits, pattern_idx
  );
endinterface

// File: rtl/xor_net_bist.sv
// Built-in self-test for the 3-input XOR network: walks all 8 binary operand
// patterns, thresholds each result and compares it against the XOR parity.
module xor_net_bist #(
  parameter int                       DATA_W        = 16,
  parameter int                       SETTLE_CYCLES = 4,
  parameter logic signed [DATA_W-1:0] THRESH        = 16'sh0080
) (
  input  logic           clk,
  input  logic           rst,
  xor_net_bist_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int                       CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic signed [DATA_W-1:0] ONE      = DATA_W'(256);  // 1.0 in Q8.8

  state_t                   state_q, state_d;
  logic [2:0]               idx_q, idx_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [7:0]               fail_mask_q, fail_mask_d;
  logic [7:0]               result_bits_q, result_bits_d;
  logic                     pass_q, pass_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic signed [DATA_W-1:0] net_a_q, net_a_d;
  logic signed [DATA_W-1:0] net_b_q, net_b_d;
  logic signed [DATA_W-1:0] net_c_q, net_c_d;
  logic                     dec_bit;

  function automatic logic signed [DATA_W-1:0] enc(input logic b);
    return b ? ONE : '0;
  endfunction

  // Both operands are signed, so negative results never exceed the threshold.
  assign dec_bit = (bus.net_result > THRESH);

  // NOTE: every variable gets its hold/default value before the case so no
  // path leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    fail_mask_d   = fail_mask_q;
    result_bits_d = result_bits_q;
    pass_d        = pass_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    net_a_d       = net_a_q;
    net_b_d       = net_b_q;
    net_c_d       = net_c_q;

    case (state_q)
      IDLE: begin
        net_a_d = '0;
        net_b_d = '0;
        net_c_d = '0;
        if (bus.start) begin
          idx_d         = '0;
          cnt_d         = '0;
          fail_mask_d   = '0;
          result_bits_d = '0;
          pass_d        = 1'b0;
          busy_d        = 1'b1;
          state_d       = SETTLE;
        end
      end

      SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = SAMPLE;
      end

      SAMPLE: begin
        result_bits_d[idx_q] = dec_bit;
        fail_mask_d[idx_q]   = dec_bit ^ (^idx_q);
        if (idx_q != 3'd7) begin
          idx_d   = idx_q + 3'd1;
          net_a_d = enc(idx_d[2]);
          net_b_d = enc(idx_d[1]);
          net_c_d = enc(idx_d[0]);
          cnt_d   = '0;
          state_d = SETTLE;
        end else begin
          // Pass includes the mismatch bit written on this same edge.
          pass_d  = (fail_mask_d == 8'h00);
          busy_d  = 1'b0;
          done_d  = 1'b1;
          net_a_d = '0;
          net_b_d = '0;
          net_c_d = '0;
          state_d = DONE;
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      fail_mask_q   <= '0;
      result_bits_q <= '0;
      pass_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      net_a_q       <= '0;
      net_b_q       <= '0;
      net_c_q       <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      fail_mask_q   <= fail_mask_d;
      result_bits_q <= result_bits_d;
      pass_q        <= pass_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      net_a_q       <= net_a_d;
      net_b_q       <= net_b_d;
      net_c_q       <= net_c_d;
    end
  end

  assign bus.net_a       = net_a_q;
  assign bus.net_b       = net_b_q;
  assign bus.net_c       = net_c_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.fail_mask   = fail_mask_q;
  assign bus.result_bits = result_bits_q;
  assign bus.pattern_idx = idx_q;

endmodule

// File: tb/tb_xor_net_bist.sv
// Directed bench for xor_net_bist: golden and stuck network outputs, threshold
// boundaries, mid-run reset and back-to-back runs with start held high.
module tb_xor_net_bist;

  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              golden_en = 1'b1;
  logic signed [15:0] tie_val = 16'sh0000;
  logic signed [15:0] model_q = 16'sh0000;
  int                tests_run = 0;
  int                tests_failed = 0;

  xor_net_bist_if #(.DATA_W(DATA_W)) bus ();

  xor_net_bist #(
    .DATA_W        (DATA_W),
    .SETTLE_CYCLES (4),
    .THRESH        (16'sh0080)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference network: XOR of the three operands, one cycle of latency.
  always @(posedge clk)
    model_q <= ((bus.net_a != 0) ^ (bus.net_b != 0) ^ (bus.net_c != 0)) ? 16'sh0100 : 16'sh0000;

  assign bus.net_result = golden_en ? model_q : tie_val;

  function automatic logic signed [15:0] op(input logic b);
    return b ? 16'sh0100 : 16'sh0000;
  endfunction

  function automatic logic [69:0] all_outs();
    return {bus.net_a, bus.net_b, bus.net_c, bus.busy, bus.done, bus.pass,
            bus.fail_mask, bus.result_bits, bus.pattern_idx};
  endfunction

  // Raises start for exactly one active edge; returns 1 time unit after it.
  task automatic start_run();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Samples at each falling edge; k = 0 is the sample right after the start edge.
  task automatic wait_done(output int k_done);
    k_done = -1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        k_done = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    tests_run++;
    if (all_outs() !== 70'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (all_outs() !== 70'd0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: got %h expected 0", all_outs());
    end
  endtask

  task automatic test_golden();
    logic [2:0]  p;
    logic [50:0] got, exp;
    int          bad_vec = 0, bad_ctl = 0;
    golden_en = 1'b1;
    start_run();
    for (int k = 0; k <= 42; k++) begin
      @(negedge clk);
      if (k < 40) begin
        p   = 3'(k / 5);
        got = {bus.net_a, bus.net_b, bus.net_c, bus.pattern_idx};
        exp = {op(p[2]), op(p[1]), op(p[0]), p};
        tests_run++;
        if (got !== exp) begin
          tests_failed++;
          bad_vec++;
          if (bad_vec < 4) $display("FAIL golden_pattern k=%0d: got %h expected %h", k, got, exp);
        end
      end
      tests_run++;
      if ({bus.done, bus.busy} !== {k == 40, k < 40}) begin
        tests_failed++;
        bad_ctl++;
        if (bad_ctl < 4)
          $display("FAIL golden_done_busy k=%0d: got %b expected %b", k, {bus.done, bus.busy}, {k == 40, k < 40});
      end
    end
    tests_run++;
    if ({bus.pass, bus.fail_mask, bus.result_bits} !== {1'b1, 8'h00, 8'h96}) begin
      tests_failed++;
      $display("FAIL golden_result: pass/mask/bits got %b/%h/%h expected 1/00/96",
               bus.pass, bus.fail_mask, bus.result_bits);
    end
  endtask

  task automatic test_tied(input logic signed [15:0] val, input logic [7:0] exp_bits,
                           input logic [7:0] exp_mask, input string name);
    int k_done;
    golden_en = 1'b0;
    tie_val   = val;
    start_run();
    wait_done(k_done);
    tests_run++;
    if (k_done != 40) begin
      tests_failed++;
      $display("FAIL %s_latency: done at %0d expected 40", name, k_done);
    end
    tests_run++;
    if ({bus.pass, bus.fail_mask, bus.result_bits} !== {1'b0, exp_mask, exp_bits}) begin
      tests_failed++;
      $display("FAIL %s: pass/mask/bits got %b/%h/%h expected 0/%h/%h",
               name, bus.pass, bus.fail_mask, bus.result_bits, exp_mask, exp_bits);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    int   k_done;
    logic seen3 = 1'b0;
    logic done_seen = 1'b0;
    golden_en = 1'b1;
    start_run();
    for (int k = 0; k < 60 && !seen3; k++) begin
      @(negedge clk);
      if (bus.pattern_idx === 3'd3) seen3 = 1'b1;
    end
    tests_run++;
    if (!seen3) begin
      tests_failed++;
      $display("FAIL midrun_reach_p3: pattern 3 not reached within 60 cycles");
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (all_outs() !== 70'd0) begin
      tests_failed++;
      $display("FAIL midrun_async_clear: got %h expected 0", all_outs());
    end
    repeat (5) begin
      @(negedge clk);
      if (bus.done !== 1'b0) done_seen = 1'b1;
    end
    rst = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) done_seen = 1'b1;
    end
    tests_run++;
    if (done_seen) begin
      tests_failed++;
      $display("FAIL midrun_no_done: done or busy seen after reset, expected both 0");
    end
    start_run();
    wait_done(k_done);
    tests_run++;
    if (k_done != 40 || {bus.pass, bus.fail_mask, bus.result_bits} !== {1'b1, 8'h00, 8'h96}) begin
      tests_failed++;
      $display("FAIL midrun_fresh_run: done at %0d pass/mask/bits %b/%h/%h expected 40 1/00/96",
               k_done, bus.pass, bus.fail_mask, bus.result_bits);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    golden_en = 1'b0;
    tie_val   = 16'sh0000;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 126; k++) begin
      @(negedge clk);
      case (k)
        40: begin
          tests_run++;
          if ({bus.done, bus.fail_mask} !== {1'b1, 8'h96}) begin
            tests_failed++;
            $display("FAIL b2b_first_done: done/mask got %b/%h expected 1/96", bus.done, bus.fail_mask);
          end
        end
        41: begin
          golden_en = 1'b1;
          tests_run++;
          if ({bus.done, bus.busy} !== 2'b00) begin
            tests_failed++;
            $display("FAIL b2b_gap: done/busy got %b expected 00", {bus.done, bus.busy});
          end
        end
        42, 84: begin
          tests_run++;
          if ({bus.busy, bus.pass, bus.fail_mask, bus.result_bits, bus.pattern_idx} !== {2'b10, 16'h0000, 3'd0}) begin
            tests_failed++;
            $display("FAIL b2b_restart k=%0d: busy/pass/mask/bits/idx got %b/%b/%h/%h/%0d expected 1/0/00/00/0",
                     k, bus.busy, bus.pass, bus.fail_mask, bus.result_bits, bus.pattern_idx);
          end
        end
        60: begin
          tests_run++;
          if ({bus.busy, bus.pattern_idx} !== {1'b1, 3'd3}) begin
            tests_failed++;
            $display("FAIL b2b_no_restart: busy/idx got %b/%0d expected 1/3", bus.busy, bus.pattern_idx);
          end
        end
        82: begin
          tests_run++;
          if ({bus.done, bus.pass, bus.fail_mask, bus.result_bits} !== {2'b11, 8'h00, 8'h96}) begin
            tests_failed++;
            $display("FAIL b2b_second_done: done/pass/mask/bits got %b/%b/%h/%h expected 1/1/00/96",
                     bus.done, bus.pass, bus.fail_mask, bus.result_bits);
          end
        end
        100: bus.start = 1'b0;
        124: begin
          tests_run++;
          if ({bus.done, bus.pass} !== 2'b11) begin
            tests_failed++;
            $display("FAIL b2b_third_done: done/pass got %b expected 11", {bus.done, bus.pass});
          end
        end
        126: begin
          tests_run++;
          if ({bus.busy, bus.done} !== 2'b00) begin
            tests_failed++;
            $display("FAIL b2b_idle_after_release: busy/done got %b expected 00", {bus.busy, bus.done});
          end
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    bus.start = 1'b0;
    test_reset();
    test_golden();
    repeat (2) @(negedge clk);
    test_tied(16'sh0000, 8'h00, 8'h96, "tied_zero");
    test_tied(16'sh0080, 8'h00, 8'h96, "tied_thresh");
    test_tied(16'sh0081, 8'hFF, 8'h69, "tied_above");
    test_tied(16'shFF00, 8'h00, 8'h96, "tied_negative");
    test_reset_midrun();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
